// File: rtl/seq_divider_32bit.sv
// rtl/seq_divider_32bit.sv - multi-cycle restoring divider for DIV/DIVU (quotient=LO, remainder=HI)
module seq_divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;

    // acc starts as |dividend| and fills with quotient bits as dividend bits shift out
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] orig_dvd;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] acc_nxt;

    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Operand magnitudes; negating -2^(W-1) wraps to itself, which read unsigned is 2^(W-1)
    always_comb begin
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
    end

    // One restoring step: shift in next dividend bit, trial-subtract on WIDTH+1 bits, keep or restore
    always_comb begin
        rem_sh  = {rem, acc[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, dvs});
        diff    = rem_sh[WIDTH-1:0] - dvs;
        rem_nxt = ge ? diff : rem_sh[WIDTH-1:0];
        acc_nxt = {acc[WIDTH-2:0], ge};
    end

    // Final sign correction; divide-by-zero bypasses it and returns all-ones / original dividend
    always_comb begin
        q_final = q_neg ? (~acc + 1'b1) : acc;
        r_final = r_neg ? (~rem + 1'b1) : rem;
        if (dz) begin
            q_final = '1;
            r_final = orig_dvd;
        end
    end

    // Control: IDLE accepts start, ITER runs WIDTH steps, FIX publishes and pulses done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Working registers: loaded on an accepted start, stepped during ITER, untouched otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            rem      <= '0;
            dvs      <= '0;
            orig_dvd <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
        end else if (state == S_IDLE && start) begin
            acc      <= dvd_mag;
            rem      <= '0;
            dvs      <= dvs_mag;
            orig_dvd <= dividend;
            q_neg    <= dvd_neg ^ dvs_neg;
            r_neg    <= dvd_neg;
            dz       <= (divisor == '0);
        end else if (state == S_ITER) begin
            acc <= acc_nxt;
            rem <= rem_nxt;
        end
    end

    // Architectural results: written only in FIX, held until the next operation completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == S_FIX) begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= dz;
        end
    end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// tb/tb_seq_divider_32bit.sv - randomized self-checking bench for seq_divider_32bit
module tb_seq_divider_32bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int vectors;
    int miscompares;

    seq_divider_32bit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics via 64-bit truncating arithmetic
    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        z = (b == 32'd0);
        if (z) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                               input logic ez, input bit inject);
        int n;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == 1) check({tag, " busy"}, {31'd0, busy}, 32'd1);
            if (done) begin
                n = i;
                break;
            end
            if (inject && i == 5) begin
                start     = 1'b1;
                dividend  = $urandom;
                divisor   = $urandom_range(1, 50);
                is_signed = ~is_signed;
            end
        end
        check({tag, " latency"}, n, 32'd33);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " dz"}, {31'd0, div_by_zero}, {31'd0, ez});
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_rand(input string tag);
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        sgn = 1'($urandom);
        a   = $urandom;
        case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
            default: b = $urandom;
        endcase
        if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
        ref_div(sgn, a, b, q, r, z);
        launch(sgn, a, b);
        wait_result(tag, q, r, z, 1'b0);
    endtask

    initial begin
        bit saw_done;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        is_signed   = 1'b0;
        dividend    = '0;
        divisor     = '0;
        #12;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        check("rst dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, chained so each start lands in the previous done cycle
        launch(1'b0, 32'd100, 32'd7);
        wait_result("divu_100_7", 32'd14, 32'd2, 1'b0, 1'b0);
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_result("div_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("divu_big", 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        launch(1'b0, 32'h1234_5678, 32'd0);
        wait_result("divu_dz", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        launch(1'b1, 32'h1234_5678, 32'd0);
        wait_result("div_dz", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        launch(1'b1, 32'hFFFF_FFF0, 32'd0);
        wait_result("div_neg_dz", 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0);
        launch(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_result("div_inject", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b1);

        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // Reset during iteration 10 aborts without a done pulse
        launch(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort dz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort no_done", {31'd0, saw_done}, 32'd0);
        launch(1'b0, 32'd1000, 32'd3);
        wait_result("after_abort", 32'd333, 32'd1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_rand($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
